// File: rtl/data_cache_pkg.sv
// Shared widths, cache line layout and tag helper for the direct-mapped data cache.
package data_cache_pkg;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 64;
    localparam int OFFSET_W  = 3;
    // Tag storage is sized for the smallest index; unused high bits stay zero.
    localparam int TAG_MAX_W = ADDR_W - OFFSET_W;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [DATA_W-1:0]    data;
    } cache_line_t;

    function automatic logic [TAG_MAX_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                      input int idx_w);
        logic [ADDR_W-1:0] shifted;
        shifted = addr >> (OFFSET_W + idx_w);
        return shifted[TAG_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/data_cache.sv
// Direct-mapped, write-through data cache with an internal backing RAM and 1-cycle reads.
// Define DATA_CACHE_WRITE_ALLOCATE_EN to allocate lines on write misses (default: no-allocate).
module data_cache
    import data_cache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int RAM_DEPTH = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic [DATA_W-1:0] ram_r [RAM_DEPTH];
    cache_line_t       lines_r [NUM_LINES];

    logic [IDX_W-1:0]     idx;
    logic [TAG_MAX_W-1:0] tag;
    logic [RAM_AW-1:0]    ram_addr;
    logic [DATA_W-1:0]    ram_word;
    cache_line_t          cur_line;
    logic                 hit;

    always_comb begin
        idx      = addr_i[OFFSET_W +: IDX_W];
        tag      = addr_tag(addr_i, IDX_W);
        ram_addr = addr_i[OFFSET_W +: RAM_AW];
        ram_word = ram_r[ram_addr];
        cur_line = lines_r[idx];
        hit      = cur_line.valid && (cur_line.tag == tag);
    end

    // Backing store: write-through on every accepted write, never reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en_i) begin
            ram_r[ram_addr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_r[i].valid <= 1'b0;
            end
            data_o <= '0;
        end else if (wr_en_i) begin
`ifdef DATA_CACHE_WRITE_ALLOCATE_EN
            lines_r[idx] <= '{valid: 1'b1, tag: tag, data: data_i};
`else
            if (hit) begin
                lines_r[idx].data <= data_i;
            end
`endif
        end else if (rd_en_i) begin
            if (hit) begin
                data_o <= cur_line.data;
            end else begin
                data_o       <= ram_word;
                lines_r[idx] <= '{valid: 1'b1, tag: tag, data: ram_word};
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a flat memory model predicts data_o, since a
// correct cache must be invisible to the reader.
module tb_data_cache;

    localparam int RAM_DEPTH = 1024;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic        rd_en_i = 1'b0;
    logic [63:0] addr_i = '0;
    logic [63:0] data_i = '0;
    logic [63:0] data_o;

    data_cache #(.NUM_LINES(8), .RAM_DEPTH(RAM_DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en_i (wr_en_i),
        .rd_en_i (rd_en_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Reference model: flat word memory plus the last read value.
    logic [63:0] mem [RAM_DEPTH];
    logic [63:0] model_q = '0;
    logic [63:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int word_of(input logic [63:0] a);
        return int'((a / 8) % RAM_DEPTH);
    endfunction

    // One bus cycle: drive, predict, clock, compare.
    task automatic cycle(input logic r, input logic w, input logic rd,
                         input logic [63:0] a, input logic [63:0] d, input string name);
        rst_i = r; wr_en_i = w; rd_en_i = rd; addr_i = a; data_i = d;
        if (r) model_q = '0;
        else if (w) mem[word_of(a)] = d;
        else if (rd) model_q = mem[word_of(a)];
        exp_q.push_back(model_q);
        @(posedge clk_i);
        #1;
        check(name, data_o, exp_q.pop_front());
        rst_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
    endtask

    task automatic do_reset();                          cycle(1'b1, 1'b0, 1'b0, '0, '0, "reset");   endtask
    task automatic do_read(input logic [63:0] a);       cycle(1'b0, 1'b0, 1'b1, a, '0, "read");     endtask
    task automatic do_write(input logic [63:0] a, input logic [63:0] d); cycle(1'b0, 1'b1, 1'b0, a, d, "write"); endtask
    task automatic do_both(input logic [63:0] a, input logic [63:0] d);  cycle(1'b0, 1'b1, 1'b1, a, d, "rd_wr"); endtask
    task automatic do_idle();                           cycle(1'b0, 1'b0, 1'b0, '0, '0, "idle");    endtask

    initial begin
        logic [63:0] a, d;
        int sel;

        do_reset();
        check("reset_data_o", data_o, 64'h0);

        // Preload the backing memory through the write-through path.
        for (int k = 0; k < RAM_DEPTH; k++) begin
            do_write(64'(k) * 8, 64'h1000_0000_0000_0000 + 64'(k));
        end
        do_reset();

        // Directed scenarios with literal expected values.
        do_read(64'h0);
        check("first_read", data_o, 64'h1000_0000_0000_0000);
        do_read(64'h100);
        check("seq_100", data_o, 64'h1000_0000_0000_0020);
        do_read(64'h200);
        check("seq_200", data_o, 64'h1000_0000_0000_0040);
        do_read(64'h0);
        check("seq_0", data_o, 64'h1000_0000_0000_0000);
        do_read(64'h40);
        check("conflict_40", data_o, 64'h1000_0000_0000_0008);
        do_read(64'h0);
        check("refill_0", data_o, 64'h1000_0000_0000_0000);

        do_read(64'h500);
        do_write(64'h500, 64'hDEAD_BEEF);
        do_read(64'h500);
        check("raw_500", data_o, 64'hDEAD_BEEF);
        check("ram_a0", dut.ram_r[10'hA0], 64'hDEAD_BEEF);

        do_both(64'h600, 64'h55);
        check("both_hold", data_o, 64'hDEAD_BEEF);
        check("ram_c0", dut.ram_r[10'hC0], 64'h55);
        do_read(64'h600);
        check("read_c0", data_o, 64'h55);
        do_idle();
        check("idle_hold", data_o, 64'h55);

        do_read(64'h0);
        cycle(1'b1, 1'b0, 1'b1, 64'h0, '0, "reset_with_read");
        check("reset_cycle", data_o, 64'h0);
        do_read(64'h0);
        check("refetch_0", data_o, 64'h1000_0000_0000_0000);
        cycle(1'b1, 1'b1, 1'b0, 64'h8, 64'hBAD, "reset_with_write");
        check("reset_drops_write", dut.ram_r[1], 64'h1000_0000_0000_0001);

        // Randomized traffic, mostly over a small window to exercise hits and conflicts.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, RAM_DEPTH - 1)) * 8;
            else a = 64'($urandom_range(0, 31)) * 8;
            a = a | 64'($urandom_range(0, 7));
            d = {$urandom, $urandom};
            sel = $urandom_range(0, 99);
            if (sel < 2) do_reset();
            else if (sel < 12) do_both(a, d);
            else if (sel < 42) do_write(a, d);
            else if (sel < 90) do_read(a);
            else do_idle();
        end

        for (int k = 0; k < 64; k++) begin
            check("ram_final", dut.ram_r[k], mem[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
